// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply (shift-add) / divide (restoring) unit that reads its
// operands from the register file and writes a two-byte result back through its write port.
module muldiv_seq #(
  parameter int WIDTH      = 8,
  parameter int AW         = 3,
  parameter bit WRITE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs_a,
  input  logic [AW-1:0]    rs_b,
  output logic [AW-1:0]    A_addr,
  output logic [AW-1:0]    B_addr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [AW-1:0]    writeAddr,
  output logic [WIDTH-1:0] data,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB_LO, WB_HI} state_t;

  state_t           state_reg, state_next;
  logic             op_reg, op_next;
  logic [AW-1:0]    rd_reg, rd_next;
  logic [AW-1:0]    a_addr_reg, a_addr_next;
  logic [AW-1:0]    b_addr_reg, b_addr_next;
  logic [WIDTH-1:0] opnd_reg, opnd_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dz_reg, dz_next;
  logic [AW-1:0]    waddr_hold_reg, waddr_hold_next;
  logic [WIDTH-1:0] data_hold_reg, data_hold_next;

  // hi/lo form one 2*WIDTH shift register: product {hi,lo} for MUL, {remainder,quotient} for DIV
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  assign mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  // Only used when div_ge holds, so the true difference always fits in WIDTH bits
  assign div_rem   = div_shift[WIDTH-1:0] - opnd_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      op_reg         <= 1'b0;
      rd_reg         <= '0;
      a_addr_reg     <= '0;
      b_addr_reg     <= '0;
      opnd_reg       <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      cnt_reg        <= '0;
      dz_reg         <= 1'b0;
      waddr_hold_reg <= '0;
      data_hold_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      rd_reg         <= rd_next;
      a_addr_reg     <= a_addr_next;
      b_addr_reg     <= b_addr_next;
      opnd_reg       <= opnd_next;
      hi_reg         <= hi_next;
      lo_reg         <= lo_next;
      cnt_reg        <= cnt_next;
      dz_reg         <= dz_next;
      waddr_hold_reg <= waddr_hold_next;
      data_hold_reg  <= data_hold_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    rd_next         = rd_reg;
    a_addr_next     = a_addr_reg;
    b_addr_next     = b_addr_reg;
    opnd_next       = opnd_reg;
    hi_next         = hi_reg;
    lo_next         = lo_reg;
    cnt_next        = cnt_reg;
    dz_next         = dz_reg;
    waddr_hold_next = waddr_hold_reg;
    data_hold_next  = data_hold_reg;
    en              = 1'b0;
    done            = 1'b0;
    writeAddr       = waddr_hold_reg;
    data            = data_hold_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next     = op;
          rd_next     = rd;
          a_addr_next = rs_a;
          b_addr_next = rs_b;
          dz_next     = 1'b0;
          state_next  = READ;
        end
      end
      READ: begin
        if (op_reg && (B == '0)) begin
          lo_next    = {WIDTH{1'b1}};
          hi_next    = A;
          dz_next    = 1'b1;
          state_next = WB_LO;
        end else begin
          // MUL keeps the multiplicand and shifts the multiplier out of lo; DIV shifts the dividend
          hi_next    = '0;
          lo_next    = op_reg ? A : B;
          opnd_next  = op_reg ? B : A;
          cnt_next   = CW'(WIDTH - 1);
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!op_reg) begin
          hi_next = mul_sum[WIDTH:1];
          lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else if (div_ge) begin
          hi_next = div_rem;
          lo_next = {lo_reg[WIDTH-2:0], 1'b1};
        end else begin
          hi_next = div_shift[WIDTH-1:0];
          lo_next = {lo_reg[WIDTH-2:0], 1'b0};
        end
        if (cnt_reg == '0) state_next = WB_LO;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      WB_LO: begin
        en              = 1'b1;
        writeAddr       = rd_reg;
        data            = lo_reg;
        waddr_hold_next = rd_reg;
        data_hold_next  = lo_reg;
        if (WRITE_HIGH) begin
          state_next = WB_HI;
        end else begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      WB_HI: begin
        en              = 1'b1;
        done            = 1'b1;
        writeAddr       = rd_reg + AW'(1);
        data            = hi_reg;
        waddr_hold_next = rd_reg + AW'(1);
        data_hold_next  = hi_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign A_addr   = a_addr_reg;
  assign B_addr   = b_addr_reg;
  assign busy     = (state_reg != IDLE);
  assign div_zero = dz_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: models the register file, queues expected writebacks
// at issue time and compares them against every en cycle, plus cycle-exact control checks.
module tb_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, op;
  logic [2:0] rd, rs_a, rs_b;
  logic [2:0] A_addr, B_addr, writeAddr;
  logic [7:0] A, B, data;
  logic       en, busy, done, div_zero;

  logic [7:0]  regs [8];
  logic [10:0] exp_q [$];   // {addr, data}
  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(8), .AW(3), .WRITE_HIGH(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rd(rd), .rs_a(rs_a), .rs_b(rs_b),
    .A_addr(A_addr), .B_addr(B_addr), .A(A), .B(B), .writeAddr(writeAddr), .data(data),
    .en(en), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  assign A = regs[A_addr];
  assign B = regs[B_addr];
  always @(posedge clk) if (en) regs[writeAddr] <= data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one operation and follow it cycle by cycle until one cycle after it returns to IDLE.
  task automatic run_op(input bit o, input logic [2:0] d, input logic [2:0] sa,
                        input logic [2:0] sb, input bit inject);
    logic [7:0]  a, b, lo, hi;
    logic [15:0] p;
    logic [10:0] e;
    bit dz;
    int lo_c, last;
    a = regs[sa];
    b = regs[sb];
    dz = o && (b == 8'h00);
    if (!o) begin
      p  = 16'(a) * 16'(b);
      lo = p[7:0];
      hi = p[15:8];
    end else if (dz) begin
      lo = 8'hFF;
      hi = a;
    end else begin
      lo = a / b;
      hi = a % b;
    end
    exp_q.push_back({d, lo});
    exp_q.push_back({d + 3'd1, hi});
    lo_c = dz ? 2 : 10;
    last = lo_c + 1;
    $display("op=%s rd=%0d rs_a=%0d rs_b=%0d a=0x%02h b=0x%02h -> lo=0x%02h hi=0x%02h",
             o ? "DIV" : "MUL", d, sa, sb, a, b, lo, hi);
    @(negedge clk);
    op = o; rd = d; rs_a = sa; rs_b = sb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; rd = 3'd5; rs_a = 3'd6; rs_b = 3'd4;
    for (int c = 1; c <= last + 1; c++) begin
      if (c == 1) begin
        check("a_addr", 32'(A_addr), 32'(sa));
        check("b_addr", 32'(B_addr), 32'(sb));
      end
      check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= last));
      check($sformatf("en_c%0d", c), 32'(en), 32'(c == lo_c || c == last));
      check($sformatf("done_c%0d", c), 32'(done), 32'(c == last));
      check($sformatf("dz_c%0d", c), 32'(div_zero), 32'(dz && c >= 2));
      if (en) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("waddr", 32'(writeAddr), 32'(e[10:8]));
          check("wdata", 32'(data), 32'(e[7:0]));
        end
      end
      start = inject && (c >= 2) && (c < last);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  logic [7:0] snap [8];

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 1'b0; rd = '0; rs_a = '0; rs_b = '0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    #3;
    check("rst_en", 32'(en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_addr", 32'({A_addr, B_addr, writeAddr}), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: 13*11
    regs[1] = 8'h0D; regs[2] = 8'h0B;
    run_op(1'b0, 3'd3, 3'd1, 3'd2, 1'b0);
    check("t1_r3", 32'(regs[3]), 32'h8F);
    check("t1_r4", 32'(regs[4]), 32'h00);

    // 2: 0xFF*0xFF, same source twice, with ignored starts while busy
    regs[5] = 8'hFF;
    run_op(1'b0, 3'd6, 3'd5, 3'd5, 1'b1);
    check("t2_r6", 32'(regs[6]), 32'h01);
    check("t2_r7", 32'(regs[7]), 32'hFE);

    // 3: 200/7
    regs[1] = 8'hC8; regs[2] = 8'h07;
    run_op(1'b1, 3'd3, 3'd1, 3'd2, 1'b1);
    check("t3_q", 32'(regs[3]), 32'h1C);
    check("t3_r", 32'(regs[4]), 32'h04);

    // 4: divide by zero; the following operation clears the flag (checked at its c1)
    regs[1] = 8'h5A; regs[2] = 8'h00;
    run_op(1'b1, 3'd3, 3'd1, 3'd2, 1'b1);
    check("t4_q", 32'(regs[3]), 32'hFF);
    check("t4_r", 32'(regs[4]), 32'h5A);
    check("t4_dz_hold", 32'(div_zero), 32'd1);

    // 5: rd=7 wraps high byte into r0, operands read before overwrite
    regs[7] = 8'h10;
    run_op(1'b0, 3'd7, 3'd7, 3'd7, 1'b0);
    check("t5_r7", 32'(regs[7]), 32'h00);
    check("t5_r0", 32'(regs[0]), 32'h01);

    // 6: reset during EXEC aborts with no writeback
    regs[1] = 8'h21; regs[2] = 8'h03;
    for (int i = 0; i < 8; i++) snap[i] = regs[i];
    $display("op=MUL rd=3 rs_a=1 rs_b=2 aborted by reset in c5");
    @(negedge clk);
    op = 1'b0; rd = 3'd3; rs_a = 3'd1; rs_b = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_en", 32'(en), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_aaddr", 32'(A_addr), 32'd0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("t6_r%0d", i), 32'(regs[i]), 32'(snap[i]));
    reset_n = 1'b1;
    run_op(1'b0, 3'd3, 3'd1, 3'd2, 1'b1);
    check("t6_lo", 32'(regs[3]), 32'h63);
    check("t6_hi", 32'(regs[4]), 32'h00);
    check("sb_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
